// File: rtl/hovalaag_step_sequencer.sv
// rtl/hovalaag_step_sequencer.sv - load/execute sequencer for the Hovalaag wrapper port; optional PC tracking via HOVSEQ_PC_TRACK_EN
module hovalaag_step_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_data,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [11:0] in1_data,
  input  logic        in1_valid,
  output logic        in1_ready,
  input  logic [11:0] in2_data,
  input  logic        in2_valid,
  output logic        in2_ready,
  output logic [11:0] out_data,
  output logic        out_chan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  pc,
  output logic        busy,
  output logic [9:0]  hov_addr,
  output logic [5:0]  hov_io_in,
  input  logic [7:0]  hov_io_out
);

  localparam logic [4:0] S_W1    = 5'd0;
  localparam logic [4:0] S_L1A   = 5'd1;
  localparam logic [4:0] S_L1B   = 5'd2;
  localparam logic [4:0] S_W2    = 5'd3;
  localparam logic [4:0] S_L2A   = 5'd4;
  localparam logic [4:0] S_L2B   = 5'd5;
  localparam logic [4:0] S_IDLE  = 5'd6;
  localparam logic [4:0] S_LOAD0 = 5'd7;
  localparam logic [4:0] S_LOAD1 = 5'd8;
  localparam logic [4:0] S_LOAD2 = 5'd9;
  localparam logic [4:0] S_LOAD3 = 5'd10;
  localparam logic [4:0] S_LOAD4 = 5'd11;
  localparam logic [4:0] S_EXEC  = 5'd12;
  localparam logic [4:0] S_OLO   = 5'd13;
  localparam logic [4:0] S_OHI   = 5'd14;
  localparam logic [4:0] S_OPUSH = 5'd15;
`ifdef HOVSEQ_PC_TRACK_EN
  localparam logic [4:0] S_PC    = 5'd16;
  localparam logic [4:0] S_TAIL  = S_PC;
`else
  localparam logic [4:0] S_TAIL  = S_IDLE;
`endif

  logic [4:0]  state, state_nxt;
  logic        priming;
  logic [11:0] sh1, sh2, sh1_nxt, sh2_nxt;
  logic [31:0] ir, ir_nxt;
  logic        adv1, adv2, ov2;
  logic [9:0]  addr_nxt;
  logic [5:0]  data_nxt;

  assign instr_ready = (state == S_IDLE);
  assign in1_ready   = (state == S_W1);
  assign in2_ready   = (state == S_W2);
  assign out_valid   = (state == S_OPUSH);
  assign out_chan    = ov2;
  assign busy        = (state != S_IDLE);

  // Values captured by this cycle's handshakes, so the next state's write data is already correct
  always_comb begin
    sh1_nxt = (state == S_W1 && in1_valid) ? in1_data : sh1;
    sh2_nxt = (state == S_W2 && in2_valid) ? in2_data : sh2;
    ir_nxt  = (state == S_IDLE && instr_valid) ? instr_data : ir;
  end

  // Next-state: phases after EXEC run output, IN1, IN2, PC in that order, skipping absent ones
  always_comb begin
    state_nxt = state;
    case (state)
      S_W1:    if (in1_valid) state_nxt = S_L1A;
      S_L1A:   state_nxt = S_L1B;
      S_L1B:   state_nxt = (priming || adv2) ? S_W2 : S_TAIL;
      S_W2:    if (in2_valid) state_nxt = S_L2A;
      S_L2A:   state_nxt = S_L2B;
      S_L2B:   state_nxt = priming ? S_IDLE : S_TAIL;
      S_IDLE:  if (instr_valid) state_nxt = S_LOAD0;
      S_LOAD0: state_nxt = S_LOAD1;
      S_LOAD1: state_nxt = S_LOAD2;
      S_LOAD2: state_nxt = S_LOAD3;
      S_LOAD3: state_nxt = S_LOAD4;
      S_LOAD4: state_nxt = S_EXEC;
      S_EXEC: begin
        if (hov_io_out[2] || hov_io_out[3]) state_nxt = S_OLO;
        else if (hov_io_out[0])             state_nxt = S_W1;
        else if (hov_io_out[1])             state_nxt = S_W2;
        else                                state_nxt = S_TAIL;
      end
      S_OLO:   state_nxt = S_OHI;
      S_OHI:   state_nxt = S_OPUSH;
      S_OPUSH: begin
        if (out_ready) begin
          if (adv1)      state_nxt = S_W1;
          else if (adv2) state_nxt = S_W2;
          else           state_nxt = S_TAIL;
        end
      end
`ifdef HOVSEQ_PC_TRACK_EN
      S_PC:    state_nxt = S_IDLE;
`endif
      default: state_nxt = S_W1;
    endcase
  end

  // Wrapper address/data for the upcoming state; reads at 6..9 rewrite the shadow slice
  always_comb begin
    addr_nxt = 10'h000;
    data_nxt = 6'h00;
    case (state_nxt)
      S_L1A:   begin addr_nxt = 10'h040; data_nxt = sh1_nxt[5:0];  end
      S_L1B:   begin addr_nxt = 10'h080; data_nxt = sh1_nxt[11:6]; end
      S_L2A:   begin addr_nxt = 10'h100; data_nxt = sh2_nxt[5:0];  end
      S_L2B:   begin addr_nxt = 10'h200; data_nxt = sh2_nxt[11:6]; end
      S_LOAD0: begin addr_nxt = 10'h001; data_nxt = ir_nxt[5:0];   end
      S_LOAD1: begin addr_nxt = 10'h002; data_nxt = ir_nxt[11:6];  end
      S_LOAD2: begin addr_nxt = 10'h004; data_nxt = ir_nxt[17:12]; end
      S_LOAD3: begin addr_nxt = 10'h008; data_nxt = ir_nxt[23:18]; end
      S_LOAD4: begin addr_nxt = 10'h010; data_nxt = ir_nxt[29:24]; end
      S_EXEC:  begin addr_nxt = 10'h020; data_nxt = {4'b0000, ir_nxt[31:30]}; end
      S_OLO:   begin addr_nxt = 10'h080; data_nxt = sh1_nxt[11:6]; end
      S_OHI:   begin addr_nxt = 10'h100; data_nxt = sh2_nxt[5:0];  end
`ifdef HOVSEQ_PC_TRACK_EN
      S_PC:    begin addr_nxt = 10'h040; data_nxt = sh1_nxt[5:0];  end
`endif
      default: begin addr_nxt = 10'h000; data_nxt = 6'h00; end
    endcase
  end

  // State, wrapper port registers, shadows and status/output captures
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_W1;
      priming   <= 1'b1;
      hov_addr  <= 10'h000;
      hov_io_in <= 6'h00;
      sh1       <= 12'h000;
      sh2       <= 12'h000;
      ir        <= 32'h0;
      adv1      <= 1'b0;
      adv2      <= 1'b0;
      ov2       <= 1'b0;
      out_data  <= 12'h000;
    end else begin
      state     <= state_nxt;
      hov_addr  <= addr_nxt;
      hov_io_in <= data_nxt;
      sh1       <= sh1_nxt;
      sh2       <= sh2_nxt;
      ir        <= ir_nxt;
      if (state == S_L2B && priming) priming <= 1'b0;
      if (state == S_EXEC) begin
        adv1 <= hov_io_out[0];
        adv2 <= hov_io_out[1];
        ov2  <= hov_io_out[3];
      end
      if (state == S_OLO) out_data[7:0]  <= hov_io_out;
      if (state == S_OHI) out_data[11:8] <= hov_io_out[3:0];
    end
  end

`ifdef HOVSEQ_PC_TRACK_EN
  // PC readback captured at the end of the PC phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          pc <= 8'h00;
    else if (state == S_PC) pc <= hov_io_out;
  end
`else
  assign pc = 8'h00;
`endif

endmodule

// File: doc/hovalaag_step_sequencer.md
# hovalaag_step_sequencer

Autonomous sequencer for the Hovalaag wrapper's one-hot, 6-bit-write / 8-bit-read port. It accepts whole 32-bit instructions and 12-bit IN1/IN2 words over valid/ready streams. It drives the wrapper's addr/io_in phases to load and execute each instruction, refreshes IN1/IN2 when the CPU advances them, and returns OUT1/OUT2 words on an output stream. It sits between a host-side FIFO/bridge and the wrapper, replacing host bit-banging of the load/execute protocol.

## Interface
- `HOVSEQ_PC_TRACK_EN`: see Configuration (macro, not parameter); no Verilog parameters.
- `clk`  in  1  single clock; also the wrapper's clk.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instr_data`  in  32  instruction word.
- `instr_valid` / `instr_ready`  in / out  1  instruction handshake.
- `in1_data`, `in2_data`  in  12  IN1/IN2 stream words.
- `in1_valid`, `in2_valid` / `in1_ready`, `in2_ready`  in / out  1  input handshakes.
- `out_data`  out  12  captured OUT value.
- `out_chan`  out  1  0 = OUT1, 1 = OUT2.
- `out_valid` / `out_ready`  out / in  1  output handshake.
- `pc`  out  8  PC after the last executed instruction.
- `busy`  out  1  high in every state except IDLE.
- `hov_addr`  out  10  one-hot (or zero) wrapper address; registered, glitch-free.
- `hov_io_in`  out  6  wrapper write data; registered.
- `hov_io_out`  in  8  wrapper read data; combinational from `hov_addr`.

## Operation
- Moore FSM; `hov_addr`/`hov_io_in` are a registered function of state; a wrapper write happens on every clock edge ending a state with non-zero addr.
- Shadow registers `sh1`, `sh2` (12b) mirror wrapper IN1/IN2. Every state whose addr is 6–9 drives the matching shadow slice (addr6 `sh1[5:0]`, addr7 `sh1[11:6]`, addr8 `sh2[5:0]`, addr9 `sh2[11:6]`). Reads therefore never corrupt IN1/IN2.
- Reset sequence (priming): W1 → L1a → L1b → W2 → L2a → L2b → IDLE.
  - Wx (addr 0, `inx_ready`=1) waits for `inx_valid`; a transfer captures `shx`.
  - L1a/L1b: addr 6/7; L2a/L2b: addr 8/9.
- IDLE: addr 0, `instr_ready`=1; a transfer captures the instruction into `ir` → LOAD0.
- LOAD0..LOAD4: addr bit k, data `ir[6k+5:6k]`.
- EXEC: addr5, data `{4'b0, ir[31:30]}`; samples `hov_io_out[3:0]` into adv1, adv2, ov1, ov2 at the same edge that clocks the CPU.
- If ov1|ov2: OLO (addr7, capture `out_data[7:0]`) → OHI (addr8, capture `out_data[11:8]`) → OPUSH.
  - OPUSH: addr 0, `out_valid`=1, `out_chan`=ov2; holds until `out_ready`.
- If adv1: W1, L1a, L1b. Then if adv2: W2, L2a, L2b.
- Then PC (addr6, capture `pc`) → IDLE.
- Phase order after EXEC is fixed: output, IN1, IN2, PC; absent phases are skipped.
- ov1 and ov2 are never both set (single select bit); `out_chan` = ov2.

## Timing
- Reset (async assert): state W1 with priming flag; `hov_addr`=0, `hov_io_in`=0, all readies 0 except `in1_ready`=1 from the first cycle after reset deassert. `out_valid`=0, `out_data`=0, `out_chan`=0, `pc`=0, `busy`=1.
- Minimum step, no I/O: IDLE + 5 LOAD + EXEC + PC = 8 cycles per instruction, back-to-back.
- Output phase adds 3 cycles minimum; each input refresh adds 3 cycles minimum.
- `instr_ready` is asserted only in IDLE; `inx_ready` only in Wx; both are combinational from state.
- `out_data`/`out_chan` are stable while `out_valid`=1; `out_valid` drops the cycle after the handshake.
- Stream starvation (Wx with no valid) or backpressure stalls the FSM with addr 0. The CPU is never clocked while stalled.
- Mid-operation reset abandons the instruction. The host must also reset the wrapper (its reset is separate) before priming reloads IN1/IN2.

## Configuration
- `HOVSEQ_PC_TRACK_EN` defined: PC state present; `pc` updated after every instruction.
- Not defined: PC state removed (minimum step 7 cycles); `pc` tied to 0.

## Test plan
- Reset, then supply IN1=0x123, IN2=0xABC -> `hov_addr` sequence 0x040, 0x080, 0x100, 0x200 with data 0x23, 0x04, 0x3C, 0x2A; then `instr_ready`=1.
- Instruction 0x00000000 with no I/O -> `hov_addr` sequence 0x001..0x010, 0x020, 0x040 over 8 cycles; back-to-back second instruction starts LOAD0 on cycle 9.
- Instruction with ov1 (wrapper W=0x5A7) -> `out_valid`, `out_data`=0x5A7, `out_chan`=0; `out_ready` held low 4 cycles -> FSM holds, data stable.
- EXEC status 0x3 (both adv), IN1 next 0x0FF, IN2 starved 10 cycles -> IN1 refreshed first; FSM waits in W2 with addr 0; IN2 then written.
- Reads at addr 7/8 after shadows 0x123/0xABC -> `hov_io_in` = 0x04 / 0x3C; wrapper IN values unchanged.
- `reset_n` pulsed during LOAD2 -> outputs return to reset values asynchronously; priming restarts.
